mem_wr_seq: RTL and testbench

Frame write sequencer that sits directly upstream of the team's 8 x 16 dual-port frame memory.
- Accepts a stream of 16-bit words over a valid/ready handshake.
- Drives the memory's `wr_en` / `wr_addr` / `data` write port, filling addresses 0..DEPTH-1 in order.
- Raises `frame_done` once the last write has landed, then holds off new input until the downstream reader acknowledges with `frame_ack`.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_wr_csum.sv | 26 ++
 rtl/mem_wr_seq.sv | 112 +++++++++++
 tb/tb_mem_wr_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and sizing for the frame memory write path.
package mem_pkg;

   localparam int MEM_DATA_W  = 16;
   localparam int MEM_ADDR_W  = 3;
   localparam int MEM_DEPTH   = 8;
   localparam int FRAME_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_LAST = 2'd2,
      ST_DONE = 2'd3
   } wr_state_t;

endpackage

// File: rtl/mem_wr_csum.sv
// XOR accumulator over the accepted words of one frame.
// load restarts the sum with the current word; clr zeroes it.
module mem_wr_csum #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] csum
);

   // Clear has priority; otherwise fold in each accepted word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (clr) begin
         csum <= '0;
      end else if (en) begin
         csum <= load ? din : (csum ^ din);
      end
   end

endmodule

// File: rtl/mem_wr_seq.sv
// Frame write sequencer feeding the 8 x 16 dual-port frame memory.
// Optional checksum: define MEM_WR_SEQ_CSUM_EN to build the XOR accumulator,
// otherwise csum is tied to zero.
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | no word of the current frame accepted yet
//   FILL    | part of the frame accepted
//   LAST    | write of the final word is being issued
//   DONE    | frame resident in memory, waiting for frame_ack
module mem_wr_seq
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = MEM_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   in_ready,
   input  logic                   abort,
   input  logic                   frame_ack,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [DATA_W-1:0]      wr_data,
   output logic                   frame_done,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic [DATA_W-1:0]      csum
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   wr_state_t         state;
   logic [ADDR_W-1:0] ptr;
   logic              open_st;
   logic              abort_ok;
   logic              take;

   // Ready comes from registered state only; reset forces it low.
   assign open_st  = (state == ST_IDLE) || (state == ST_FILL);
   assign in_ready = rst_n && open_st;
   assign abort_ok = abort && open_st;
   // A word offered together with abort is dropped.
   assign take     = in_valid && in_ready && !abort_ok;

   // Sequencer state, write port registers and frame bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         wr_en <= take;
         if (take) begin
            wr_addr <= ptr;
            wr_data <= in_data;
         end
         case (state)
            ST_IDLE, ST_FILL: begin
               if (abort_ok) begin
                  state <= ST_IDLE;
                  ptr   <= '0;
               end else if (take) begin
                  if (ptr == LAST_PTR) begin
                     state <= ST_LAST;
                     ptr   <= '0;
                  end else begin
                     state <= ST_FILL;
                     ptr   <= ptr + 1'b1;
                  end
               end
            end
            ST_LAST: begin
               state      <= ST_DONE;
               frame_done <= 1'b1;
               frame_cnt  <= frame_cnt + 1'b1;
            end
            ST_DONE: begin
               if (frame_ack) begin
                  state      <= ST_IDLE;
                  frame_done <= 1'b0;
                  ptr        <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MEM_WR_SEQ_CSUM_EN
   mem_wr_csum #(
      .DATA_W (DATA_W)
   ) u_csum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (abort_ok),
      .load  (state == ST_IDLE),
      .en    (take),
      .din   (in_data),
      .csum  (csum)
   );
`else
   assign csum = '0;
`endif

endmodule

// File: tb/tb_mem_wr_seq.sv
// Scoreboard bench for mem_wr_seq: stimulus pushes expected writes,
// a negedge monitor pops and compares every wr_en cycle.
module tb_mem_wr_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready;
   logic        abort = 1'b0;
   logic        frame_ack = 1'b0;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        frame_done;
   logic [7:0]  frame_cnt;
   logic [15:0] csum;

   mem_wr_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .abort      (abort),
      .frame_ack  (frame_ack),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .csum       (csum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [2:0]  exp_ptr = '0;
   logic [15:0] exp_csum = '0;
   logic [7:0]  exp_cnt = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] csum_exp();
`ifdef MEM_WR_SEQ_CSUM_EN
      return exp_csum;
`else
      return 16'h0000;
`endif
   endfunction

   // Monitor: every memory write must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
            check("wr_data", 32'(wr_data), 32'(mon_e.data));
         end
      end
   end

   // Offer one word from a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [15:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("send_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back('{exp_ptr, d});
      exp_csum = (exp_ptr == 3'd0) ? d : (exp_csum ^ d);
      exp_ptr  = exp_ptr + 3'd1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Called right after the last accept: LAST now, DONE next cycle.
   task automatic finish_frame();
      check("done_in_last", 32'(frame_done), 32'd0);
      check("ready_in_last", 32'(in_ready), 32'd0);
      @(negedge clk);
      exp_cnt = exp_cnt + 8'd1;
      check("frame_done", 32'(frame_done), 32'd1);
      check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      check("csum", 32'(csum), 32'(csum_exp()));
   endtask

   task automatic ack();
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      exp_ptr   = '0;
      check("done_after_ack", 32'(frame_done), 32'd0);
      check("ready_after_ack", 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      check({tag, "_done"}, 32'(frame_done), 32'd0);
      check({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
      check({tag, "_csum"}, 32'(csum), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Frame 1: back-to-back 1..8, csum 8 when enabled
      for (int i = 1; i <= 8; i++) send(16'(i));
      finish_frame();
      check("csum_frame1", 32'(csum), 32'(csum_exp()));

      // Backpressure: valid held through DONE
      in_valid = 1'b1;
      in_data  = 16'h0100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ready", 32'(in_ready), 32'd0);
         check("bp_done", 32'(frame_done), 32'd1);
      end
      ack();
      send(16'h0100);
      // Gappy input for the rest of the frame
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         send(16'h0100 + 16'(i * 16'h0111));
      end
      finish_frame();
      ack();

      // Ignored controls: frame_ack in FILL, abort in DONE
      for (int i = 0; i < 3; i++) send(16'h0300 + 16'(i));
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      check("ack_in_fill_ready", 32'(in_ready), 32'd1);
      check("ack_in_fill_done", 32'(frame_done), 32'd0);
      for (int i = 3; i < 8; i++) send(16'h0300 + 16'(i));
      finish_frame();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_in_done", 32'(frame_done), 32'd1);
      check("abort_in_done_ready", 32'(in_ready), 32'd0);
      check("abort_in_done_cnt", 32'(frame_cnt), 32'(exp_cnt));
      check("abort_in_done_csum", 32'(csum), 32'(csum_exp()));
      ack();

      // Abort with a 4th word offered in the same cycle
      for (int i = 0; i < 3; i++) send(16'h0400 + 16'(i));
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      abort    = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      exp_ptr  = '0;
      exp_csum = '0;
      check("abort_ready", 32'(in_ready), 32'd1);
      check("abort_cnt", 32'(frame_cnt), 32'(exp_cnt));
      check("abort_csum", 32'(csum), 32'(csum_exp()));
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) send(16'h0500 + 16'(i * 3));
      finish_frame();
      ack();

      // Run until frame_cnt wraps 255 -> 0
      for (int f = 0; f < 252; f++) begin
         for (int i = 0; i < 8; i++) send(16'(f * 8 + i) ^ 16'hA5C3);
         if (f == 250) begin
            finish_frame();
            check("cnt_255", 32'(frame_cnt), 32'd255);
         end else begin
            finish_frame();
         end
         ack();
      end
      check("cnt_wrap", 32'(frame_cnt), 32'd0);

      // Reset mid-frame
      for (int i = 0; i < 3; i++) send(16'h0700 + 16'(i));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check_reset_outputs("midrst");
      exp_ptr  = '0;
      exp_cnt  = '0;
      exp_csum = '0;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      rst_n = 1'b1;
      #1;
      check("ready_after_midrst", 32'(in_ready), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 8; i++) send(16'h0800 + 16'(i));
      finish_frame();
      ack();
      repeat (2) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
